// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and default widths for the elastic pipeline stage
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CTRL_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

endpackage

// File: rtl/pipe_entry.sv
// rtl/pipe_entry.sv - one ctrl+data+valid holding register; clear drops ctrl/valid but keeps data
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear_ctrl,
  input  logic              d_valid,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear_ctrl) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= d_valid;
      ctrl  <= d_ctrl;
      data  <= d_data;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// rtl/pipe_skid_stage.sv - elastic pipeline stage with 2-entry skid buffer, freeze and flush
// Defining PIPE_PERF_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  state_t state_q, state_d;

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  logic main_load, main_clear, main_from_skid;
  logic skid_load, skid_clear;
  logic accept, release_x;

  // in_ready depends only on registered state, so out_ready never reaches it.
  assign in_ready  = (state_q != ST_FULL) & ~freeze & ~rst;
  assign out_valid = main_valid & ~freeze;
  assign accept    = in_valid & in_ready;
  assign release_x = out_valid & out_ready;

  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign occupancy = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_BUSY;
        ST_BUSY: begin
          if (accept && !release_x)      state_d = ST_FULL;
          else if (!accept && release_x) state_d = ST_EMPTY;
        end
        ST_FULL:  if (release_x) state_d = ST_BUSY;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: main_load = accept;
        ST_BUSY: begin
          if (accept && release_x) main_load  = 1'b1;
          else if (accept)         skid_load  = 1'b1;
          else if (release_x)      main_clear = 1'b1;
        end
        ST_FULL: begin
          if (release_x) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk        (clk),
    .rst        (rst),
    .load       (main_load),
    .clear_ctrl (main_clear),
    .d_valid    (main_from_skid ? skid_valid : in_valid),
    .d_ctrl     (main_from_skid ? skid_ctrl  : in_ctrl),
    .d_data     (main_from_skid ? skid_data  : in_data),
    .valid      (main_valid),
    .ctrl       (main_ctrl),
    .data       (main_data)
  );

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .clear_ctrl (skid_clear),
    .d_valid    (in_valid),
    .d_ctrl     (in_ctrl),
    .d_data     (in_data),
    .valid      (skid_valid),
    .ctrl       (skid_ctrl),
    .data       (skid_data)
  );

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (flush && state_q != ST_EMPTY && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  // Keeps CNT_W referenced when the counters are compiled out.
  logic [CNT_W-1:0] unused_perf_cnt;
  assign unused_perf_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// tb/tb_pipe_skid_stage.sv - table-driven bench with output scoreboard for pipe_skid_stage
module tb_pipe_skid_stage;

  typedef struct {
    logic        iv;
    logic [7:0]  ctrl;
    logic [31:0] data;
    logic        ordy;
    logic        frz;
    logic        fl;
    logic [1:0]  occ;
    logic        ir;
    logic        ov;
    logic [7:0]  oc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0, freeze = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_ctrl = '0;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid;
  logic [7:0]  out_ctrl;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
`ifdef PIPE_PERF_CNT_EN
  logic [3:0]  stall_cnt, flush_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [39:0] sb[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(32), .CTRL_W(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .freeze    (freeze),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef PIPE_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  function automatic vec_t mk(input logic iv, input logic [7:0] ctrl, input logic [31:0] data,
                              input logic ordy, input logic frz, input logic fl,
                              input logic [1:0] occ, input logic ir, input logic ov,
                              input logic [7:0] oc);
    vec_t v;
    v.iv = iv; v.ctrl = ctrl; v.data = data; v.ordy = ordy; v.frz = frz; v.fl = fl;
    v.occ = occ; v.ir = ir; v.ov = ov; v.oc = oc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one row, compare the pre-edge outputs, then settle the scoreboard for this edge.
  task automatic apply(input vec_t v, input string tag);
    logic [39:0] exp;
    @(negedge clk);
    in_valid = v.iv; in_ctrl = v.ctrl; in_data = v.data;
    out_ready = v.ordy; freeze = v.frz; flush = v.fl;
    #4;
    chk($sformatf("%s occupancy", tag), 40'(occupancy), 40'(v.occ));
    chk($sformatf("%s in_ready", tag), 40'(in_ready), 40'(v.ir));
    chk($sformatf("%s out_valid", tag), 40'(out_valid), 40'(v.ov));
    chk($sformatf("%s out_ctrl", tag), 40'(out_ctrl), 40'(v.oc));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk($sformatf("%s unexpected output data", tag), 40'(out_data), 40'h0_dead_beef);
      end else begin
        exp = sb.pop_front();
        chk($sformatf("%s output ctrl/data", tag), {out_ctrl, out_data}, exp);
      end
    end
    if (v.fl) sb.delete();
    else if (v.iv && v.ir) sb.push_back({v.ctrl, v.data});
    @(posedge clk);
  endtask

  initial begin
    // basic accept and release
    tbl.push_back(mk(1, 8'h05, 32'h1000, 1, 0, 0, 0, 1, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 32'h0,    1, 0, 0, 1, 1, 1, 8'h05));
    // stream 1..4 with backpressure filling the skid entry
    tbl.push_back(mk(1, 8'h21, 32'h1, 1, 0, 0, 0, 1, 0, 8'h00));
    tbl.push_back(mk(1, 8'h22, 32'h2, 0, 0, 0, 1, 1, 1, 8'h21));
    tbl.push_back(mk(1, 8'h23, 32'h3, 0, 0, 0, 2, 0, 1, 8'h21));
    tbl.push_back(mk(1, 8'h23, 32'h3, 1, 0, 0, 2, 0, 1, 8'h21));
    tbl.push_back(mk(1, 8'h23, 32'h3, 1, 0, 0, 1, 1, 1, 8'h22));
    tbl.push_back(mk(1, 8'h24, 32'h4, 1, 0, 0, 1, 1, 1, 8'h23));
    tbl.push_back(mk(0, 8'h00, 32'h0, 1, 0, 0, 1, 1, 1, 8'h24));
    // flush while FULL; 9 must never appear
    tbl.push_back(mk(1, 8'h07, 32'h7, 0, 0, 0, 0, 1, 0, 8'h00));
    tbl.push_back(mk(1, 8'h08, 32'h8, 0, 0, 0, 1, 1, 1, 8'h07));
    tbl.push_back(mk(1, 8'h09, 32'h9, 0, 0, 1, 2, 0, 1, 8'h07));
    tbl.push_back(mk(0, 8'h00, 32'h0, 1, 0, 0, 0, 1, 0, 8'h00));
    // flush in BUSY with same-cycle release (kept) and accept (dropped)
    tbl.push_back(mk(1, 8'h0A, 32'hA, 1, 0, 0, 0, 1, 0, 8'h00));
    tbl.push_back(mk(1, 8'h0B, 32'hB, 1, 0, 1, 1, 1, 1, 8'h0A));
    tbl.push_back(mk(0, 8'h00, 32'h0, 1, 0, 0, 0, 1, 0, 8'h00));
    // flush overrides freeze
    tbl.push_back(mk(1, 8'h0C, 32'hC, 0, 0, 0, 0, 1, 0, 8'h00));
    tbl.push_back(mk(0, 8'h00, 32'h0, 0, 1, 1, 1, 0, 0, 8'h0C));
    tbl.push_back(mk(0, 8'h00, 32'h0, 1, 0, 0, 0, 1, 0, 8'h00));
    // freeze for three cycles while BUSY
    tbl.push_back(mk(1, 8'h31, 32'h31, 1, 0, 0, 0, 1, 0, 8'h00));
    tbl.push_back(mk(1, 8'h32, 32'h32, 1, 1, 0, 1, 0, 0, 8'h31));
    tbl.push_back(mk(1, 8'h32, 32'h32, 1, 1, 0, 1, 0, 0, 8'h31));
    tbl.push_back(mk(1, 8'h32, 32'h32, 1, 1, 0, 1, 0, 0, 8'h31));
    tbl.push_back(mk(1, 8'h32, 32'h32, 1, 0, 0, 1, 1, 1, 8'h31));
    tbl.push_back(mk(0, 8'h00, 32'h0,  1, 0, 0, 1, 1, 1, 8'h32));
    tbl.push_back(mk(0, 8'h00, 32'h0,  1, 0, 0, 0, 1, 0, 8'h00));

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset out_valid", 40'(out_valid), 40'h0);
    chk("reset in_ready", 40'(in_ready), 40'h0);
    chk("reset out_ctrl", 40'(out_ctrl), 40'h0);
    chk("reset out_data", 40'(out_data), 40'h0);
    chk("reset occupancy", 40'(occupancy), 40'h0);
    @(negedge clk);
    rst = 1'b0;
    #4;
    chk("post-reset in_ready", 40'(in_ready), 40'h1);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("v%0d", i));

    // sustained one-per-cycle streaming
    for (int k = 0; k < 8; k++)
      apply(mk(1, 8'(8'h50 + k), 32'(32'h100 + k), 1, 0, 0, (k == 0) ? 2'd0 : 2'd1, 1,
               (k != 0), (k == 0) ? 8'h00 : 8'(8'h4F + k)), $sformatf("stream%0d", k));
    apply(mk(0, 8'h00, 32'h0, 1, 0, 0, 1, 1, 1, 8'h57), "stream_drain");
    apply(mk(0, 8'h00, 32'h0, 1, 0, 0, 0, 1, 0, 8'h00), "stream_idle");

`ifdef PIPE_PERF_CNT_EN
    chk("flush_cnt after three non-empty flushes", 40'(flush_cnt), 40'h3);
`endif

    // asynchronous reset while FULL
    apply(mk(1, 8'h41, 32'h41, 0, 0, 0, 0, 1, 0, 8'h00), "rstfill0");
    apply(mk(1, 8'h42, 32'h42, 0, 0, 0, 1, 1, 1, 8'h41), "rstfill1");
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst out_valid", 40'(out_valid), 40'h0);
    chk("midrst out_ctrl", 40'(out_ctrl), 40'h0);
    chk("midrst out_data", 40'(out_data), 40'h0);
    chk("midrst occupancy", 40'(occupancy), 40'h0);
    chk("midrst in_ready", 40'(in_ready), 40'h0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #4;
    chk("after midrst in_ready", 40'(in_ready), 40'h1);
    chk("after midrst occupancy", 40'(occupancy), 40'h0);
    chk("after midrst out_valid", 40'(out_valid), 40'h0);

`ifdef PIPE_PERF_CNT_EN
    apply(mk(1, 8'h61, 32'h61, 0, 0, 0, 0, 1, 0, 8'h00), "stall_fill");
    for (int k = 0; k < 20; k++)
      apply(mk(0, 8'h00, 32'h0, 0, 0, 0, 1, 1, 1, 8'h61), $sformatf("stall%0d", k));
    chk("stall_cnt saturation", 40'(stall_cnt), 40'hF);
    chk("flush_cnt cleared by reset", 40'(flush_cnt), 40'h0);
    apply(mk(0, 8'h00, 32'h0, 1, 0, 0, 1, 1, 1, 8'h61), "stall_drain");
`endif

    chk("scoreboard drained", 40'(sb.size()), 40'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Generic elastic pipeline stage register. It replaces the fixed per-stage registers (IF/ID/EX/MEM) with one parametrised block.
- Carries a control field (cleared to a bubble on flush) and a data field, using a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with fully registered backpressure.
- Adds freeze (hold) and flush (bubble insertion), which the fixed stage registers do not have.

Parameters:
- DATA_W, 32, width of the payload (PC, operands, ALU result, ...).
- CTRL_W, 8, width of the control field (WB_EN, MEM_R_EN, MEM_W_EN, ...); forced to 0 in bubbles.
- CNT_W, 16, width of the performance counters (used only with PIPE_PERF_CNT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous flush; discards all held entries.
- freeze  in  1  hold; blocks transfers on both sides.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept an entry.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  entry available downstream.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  control field; 0 whenever no valid entry is held.
- out_data  out  DATA_W  payload of the head entry.
- occupancy  out  2  number of held entries (0..2).

Behaviour:
- Reset and clock: reset is asynchronous, active-high on rst; the clock is clk.
- Storage:
  - main entry (head) and skid entry, each holding ctrl + data + valid.
  - state: EMPTY (0 entries), BUSY (main only), FULL (main + skid).
- Reset values:
  - state EMPTY; all entry registers 0.
  - out_valid 0, out_ctrl 0, out_data 0, occupancy 0.
  - in_ready 0 while rst is high, 1 from the first cycle after release.
- Combinational outputs:
  - in_ready = (state != FULL) & ~freeze & ~rst.
  - out_valid = main.valid & ~freeze.
  - out_ctrl = main.valid ? main.ctrl : 0.
  - out_data = main.data.
- No combinational path in_* -> out_*, and none out_ready -> in_ready.
- Handshake:
  - accept = in_valid & in_ready; release = out_valid & out_ready.
  - The upstream must hold in_ctrl/in_data stable while in_valid & ~in_ready.
- Transitions (no flush):
  - EMPTY: accept -> BUSY, main <= in.
  - BUSY: accept & ~release -> FULL, skid <= in.
  - BUSY: accept & release -> BUSY, main <= in.
  - BUSY: ~accept & release -> EMPTY.
  - FULL: release -> BUSY, main <= skid, skid.valid <= 0. Accept cannot occur in FULL.
- Freeze: no transfers occur, all registers hold, out_valid is masked.
- Flush (highest priority, synchronous):
  - Next state is EMPTY.
  - main.ctrl, skid.ctrl and both valid bits are cleared; data registers hold their values.
  - A same-cycle accept is discarded.
  - A same-cycle release counts as completed, since the downstream has already sampled it.
  - Flush overrides freeze.
- Timing:
  - Latency is 1 cycle from accept to out_valid when EMPTY.
  - Sustained throughput is 1 entry per cycle with out_ready held high.
- Reset mid-operation drops all entries immediately; there is no partial state.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - Adds output ports stall_cnt [CNT_W] and flush_cnt [CNT_W], both reset to 0.
  - stall_cnt increments on each cycle with out_valid & ~out_ready.
  - flush_cnt increments on each flush cycle with state != EMPTY.
  - Both counters saturate at all-ones and never wrap.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package pipe_pkg:
  - state typedef: ST_EMPTY=2'b00, ST_BUSY=2'b01, ST_FULL=2'b10.
  - Default width constants: DATA_W_DEF, CTRL_W_DEF, CNT_W_DEF.
- Sub-module pipe_entry: one ctrl+data+valid register with load, clear_ctrl and async reset; instantiated twice (main, skid).

Test Plan:
- Reset then in_valid=1, ctrl=8'h05, data=32'h0000_1000, out_ready=1 -> out_valid=1 next cycle with ctrl=8'h05, data=32'h1000; occupancy=1.
- Stream 4 entries (data 1..4) with out_ready low for cycles 2-3 -> occupancy reaches 2 and in_ready=0 while FULL; output order is 1,2,3,4 with no loss or duplication.
- FULL (data 7, 8) and flush=1 with in_valid=1, data=9 -> next cycle occupancy=0, out_valid=0, out_ctrl=0; data 9 is never emitted.
- BUSY and freeze=1 for 3 cycles with in_valid=1, out_ready=1 -> in_ready=0 and out_valid=0 throughout; after release the held entry emits first, then the new entry.
- rst asserted while FULL -> outputs 0 in the same cycle; after release in_ready=1 and occupancy=0.
- PIPE_PERF_CNT_EN with CNT_W=4, out_valid held and out_ready=0 for 20 cycles -> stall_cnt saturates at 4'hF.
